// File: rtl/servo_bank.sv
// rtl/servo_bank.sv - multi-channel servo PWM driver with per-channel slew limiting
module servo_bank #(
  parameter int NCH        = 4,
  parameter int AW         = 8,
  parameter int PRESC_DIV  = 556,
  parameter int PERIOD     = 1800,
  parameter int MIN_CNT    = 45,
  parameter int ANGLE_MAX  = 180,
  parameter int STEP       = 2,
  parameter int INIT_ANGLE = 90,
  localparam int CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  logic [CW-1:0]  wr_ch,
  input  logic [AW-1:0]  wr_angle,
  input  logic [NCH-1:0] ch_en,
  output logic [NCH-1:0] pwm,
  output logic [NCH-1:0] settled,
  output logic           frame_start
);

  localparam int PSW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam int PW  = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [PSW-1:0] presc;
  logic [PW-1:0]  pcnt;
  logic [PW-1:0]  pcnt_next;
  logic           tick;
  logic           wrap;

  logic [AW-1:0]  tgt         [NCH];
  logic [AW-1:0]  cur         [NCH];
  logic [AW-1:0]  cur_next    [NCH];
  logic [PW-1:0]  cmp_sh      [NCH];
  logic [PW-1:0]  cmp_sh_next [NCH];
  logic [NCH-1:0] en_sh;
  logic [NCH-1:0] en_sh_next;
  logic [NCH-1:0] pwm_next;
  logic [AW-1:0]  wr_clamped;

  // Move c toward t by at most STEP; STEP of zero jumps straight to the target.
  function automatic logic [AW-1:0] slew(input logic [AW-1:0] c, input logic [AW-1:0] t);
    logic [AW-1:0] diff;
    logic [AW-1:0] res;
    res = t;
    if (t > c) begin
      diff = t - c;
      if (STEP != 0 && 32'(diff) > 32'(STEP))
        res = c + AW'(STEP);
    end else begin
      diff = c - t;
      if (STEP != 0 && 32'(diff) > 32'(STEP))
        res = c - AW'(STEP);
    end
    return res;
  endfunction

  assign tick       = (presc == PSW'(PRESC_DIV - 1));
  assign wrap       = tick && (pcnt == PW'(PERIOD - 1));
  assign wr_clamped = (wr_angle > AW'(ANGLE_MAX)) ? AW'(ANGLE_MAX) : wr_angle;

  always_comb begin
    pcnt_next = pcnt;
    if (wrap)
      pcnt_next = '0;
    else if (tick)
      pcnt_next = pcnt + 1'b1;
  end

  // Shadow registers only move at the frame boundary, so a frame in progress is never reshaped.
  always_comb begin
    en_sh_next = wrap ? ch_en : en_sh;
    pwm_next   = '0;
    settled    = '0;
    for (int i = 0; i < NCH; i++) begin
      cur_next[i]    = cur[i];
      cmp_sh_next[i] = cmp_sh[i];
      if (wrap) begin
        cur_next[i]    = slew(cur[i], tgt[i]);
        cmp_sh_next[i] = PW'(MIN_CNT) + PW'(cur_next[i]);
      end
      pwm_next[i] = en_sh_next[i] && (pcnt_next < cmp_sh_next[i]);
      settled[i]  = (cur[i] == tgt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc       <= '0;
      pcnt        <= '0;
      pwm         <= '0;
      frame_start <= 1'b0;
      en_sh       <= '0;
      for (int i = 0; i < NCH; i++) begin
        tgt[i]    <= AW'(INIT_ANGLE);
        cur[i]    <= AW'(INIT_ANGLE);
        cmp_sh[i] <= PW'(MIN_CNT + INIT_ANGLE);
      end
    end else begin
      presc       <= tick ? '0 : presc + 1'b1;
      pcnt        <= pcnt_next;
      frame_start <= wrap;
      en_sh       <= en_sh_next;
      pwm         <= pwm_next;
      for (int i = 0; i < NCH; i++) begin
        cur[i]    <= cur_next[i];
        cmp_sh[i] <= cmp_sh_next[i];
        // Out-of-range channel indices match no entry and are dropped.
        if (wr_en && wr_ch == CW'(i))
          tgt[i] <= wr_clamped;
      end
    end
  end

endmodule

// File: tb/tb_servo_bank.sv
// tb/tb_servo_bank.sv - self-checking bench for servo_bank
module tb_servo_bank;

  localparam int NCH = 3;
  localparam int AW  = 8;
  localparam int CW  = 2;
  localparam int FR  = 40;

  logic           clk = 1'b0;
  logic           rst;
  logic           wr_en;
  logic [CW-1:0]  wr_ch;
  logic [AW-1:0]  wr_angle;
  logic [NCH-1:0] ch_en;
  logic [NCH-1:0] pwm;
  logic [NCH-1:0] settled;
  logic           frame_start;

  int checks = 0;
  int errors = 0;
  int fnum   = 0;

  typedef struct {
    int w0;
    int w1;
    int w2;
  } exp_t;
  exp_t exp_q[$];

  servo_bank #(
    .NCH(NCH), .AW(AW), .PRESC_DIV(2), .PERIOD(20), .MIN_CNT(2),
    .ANGLE_MAX(10), .STEP(1), .INIT_ANGLE(5)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_angle(wr_angle),
    .ch_en(ch_en), .pwm(pwm), .settled(settled), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_frame(input int a, input int b, input int c);
    exp_t e;
    e.w0 = a;
    e.w1 = b;
    e.w2 = c;
    exp_q.push_back(e);
  endtask

  // From reset release: counts clocks to the first frame_start and any pwm activity meanwhile.
  task automatic first_frame();
    int n;
    int hi;
    n  = 0;
    hi = 0;
    while (frame_start !== 1'b1 && n < 100) begin
      if (pwm !== '0) hi++;
      @(negedge clk);
      n++;
    end
    check("first_frame_len", n, FR);
    check("first_frame_pwm_high", hi, 0);
  endtask

  // Measures one frame's pulse widths in clocks; optionally drives a write / enable at sample act_k.
  task automatic frame(input int act_k, input logic do_wr, input logic [CW-1:0] a_ch,
                       input logic [AW-1:0] a_ang, input logic [NCH-1:0] a_en);
    int n;
    int w [NCH];
    exp_t e;
    n = 0;
    while (frame_start !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("f%0d_frame_start", fnum), frame_start, 1);
    for (int i = 0; i < NCH; i++) w[i] = 0;
    for (int k = 0; k < FR; k++) begin
      wr_en = 1'b0;
      if (k == act_k) begin
        ch_en = a_en;
        if (do_wr) begin
          wr_en    = 1'b1;
          wr_ch    = a_ch;
          wr_angle = a_ang;
        end
      end
      if (k == 1) check($sformatf("f%0d_frame_start_width", fnum), frame_start, 0);
      for (int i = 0; i < NCH; i++) if (pwm[i] === 1'b1) w[i]++;
      @(negedge clk);
    end
    wr_en = 1'b0;
    if (exp_q.size() == 0) begin
      check($sformatf("f%0d_scoreboard_empty", fnum), 1, 0);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("f%0d_width_ch0", fnum), w[0], e.w0);
      check($sformatf("f%0d_width_ch1", fnum), w[1], e.w1);
      check($sformatf("f%0d_width_ch2", fnum), w[2], e.w2);
    end
    fnum++;
  endtask

  initial begin
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_ch    = '0;
    wr_angle = '0;
    ch_en    = 3'b111;
    repeat (3) @(negedge clk);
    check("reset_pwm", pwm, 0);
    check("reset_frame_start", frame_start, 0);
    check("reset_settled", settled, 3'b111);
    rst = 1'b0;
    first_frame();

    expect_frame(14, 14, 14); frame(-1, 0, 0, 0, 3'b111);
    check("settled_idle", settled, 3'b111);

    // Slew ch0 from 5 to 8, one degree per frame
    expect_frame(14, 14, 14); frame(0, 1, 0, 8, 3'b111);
    check("settled_slew1", settled, 3'b110);
    expect_frame(16, 14, 14); frame(-1, 0, 0, 0, 3'b111);
    check("settled_slew2", settled, 3'b110);
    expect_frame(18, 14, 14); frame(-1, 0, 0, 0, 3'b111);
    check("settled_slew3", settled, 3'b111);

    // Clamp 200 -> 10 on ch1, then an out-of-range channel write
    expect_frame(20, 14, 14); frame(0, 1, 1, 200, 3'b111);
    check("settled_clamp", settled, 3'b101);
    expect_frame(20, 16, 14); frame(0, 1, 3, 0, 3'b111);
    check("settled_bad_index", settled, 3'b101);
    expect_frame(20, 18, 14); frame(-1, 0, 0, 0, 3'b111);
    expect_frame(20, 20, 14); frame(-1, 0, 0, 0, 3'b111);
    expect_frame(20, 22, 14); frame(-1, 0, 0, 0, 3'b111);
    check("settled_clamp_done", settled, 3'b111);

    // Write sampled on the wrap edge: the update at that edge still sees the old target
    expect_frame(20, 24, 14); frame(FR - 1, 1, 0, 0, 3'b111);
    check("settled_collision", settled, 3'b110);
    expect_frame(20, 24, 14); frame(-1, 0, 0, 0, 3'b111);

    // Enable drop and restore mid-pulse on ch1
    expect_frame(18, 24, 14); frame(5, 0, 0, 0, 3'b101);
    expect_frame(16, 0, 14);  frame(5, 0, 0, 0, 3'b111);
    expect_frame(14, 24, 14); frame(-1, 0, 0, 0, 3'b111);

    // Reset in the middle of a pulse
    repeat (3) @(negedge clk);
    check("pre_reset_pwm", pwm, 3'b111);
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset_pwm", pwm, 0);
    check("mid_reset_frame_start", frame_start, 0);
    check("mid_reset_settled", settled, 3'b111);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    first_frame();
    expect_frame(14, 14, 14); frame(-1, 0, 0, 0, 3'b111);
    check("post_reset_settled", settled, 3'b111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
